// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT coefficient-BRAM scheduler.
// The FSM state type is shared so the bench and debug port use one encoding.
package ntt_pkg;

  localparam int DATA_WIDTH_DEF = 12;
  localparam int ADW_DEF        = 5;
  localparam int Q              = 3329;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_ISSUE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } sched_state_e;

endpackage

// File: rtl/ntt_bram_sched_if.sv
// Dual-port BRAM requester bus plus the butterfly operand/result handshake.
// Handshake: operands transfer on a clock edge where bf_valid_o && bf_ready_i;
// bf_u_o/bf_v_o/bf_zeta_idx_o are held stable while bf_valid_o is high, and
// results are taken on the first edge with res_valid_i high while collecting.
interface ntt_bram_sched_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADW        = 5
);

  logic                  we_a_o;
  logic [ADW-1:0]        addr_a_o;
  logic [DATA_WIDTH-1:0] din_a_o;
  logic [DATA_WIDTH-1:0] dout_a_i;
  logic                  we_b_o;
  logic [ADW-1:0]        addr_b_o;
  logic [DATA_WIDTH-1:0] din_b_o;
  logic [DATA_WIDTH-1:0] dout_b_i;
  logic                  bf_valid_o;
  logic                  bf_ready_i;
  logic [DATA_WIDTH-1:0] bf_u_o;
  logic [DATA_WIDTH-1:0] bf_v_o;
  logic [ADW-1:0]        bf_zeta_idx_o;
  logic                  res_valid_i;
  logic [DATA_WIDTH-1:0] res_u_i;
  logic [DATA_WIDTH-1:0] res_v_i;

  modport master (
    output we_a_o, addr_a_o, din_a_o, we_b_o, addr_b_o, din_b_o,
    output bf_valid_o, bf_u_o, bf_v_o, bf_zeta_idx_o,
    input  dout_a_i, dout_b_i, bf_ready_i, res_valid_i, res_u_i, res_v_i
  );

  modport slave (
    input  we_a_o, addr_a_o, din_a_o, we_b_o, addr_b_o, din_b_o,
    input  bf_valid_o, bf_u_o, bf_v_o, bf_zeta_idx_o,
    output dout_a_i, dout_b_i, bf_ready_i, res_valid_i, res_u_i, res_v_i
  );

endinterface

// File: rtl/ntt_addr_gen.sv
// Stage/butterfly counters for an in-place radix-2 Cooley-Tukey pass, with the
// derived pair addresses, twiddle index and last-butterfly flag.
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int ADW = ADW_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clear_i,
  input  logic           advance_i,
  output logic [ADW-1:0] addr_a_o,
  output logic [ADW-1:0] addr_b_o,
  output logic [ADW-1:0] zeta_idx_o,
  output logic           last_o
);

  localparam int SW = $clog2(ADW + 1);
  localparam int KW = ADW - 1;
  localparam logic [ADW-1:0] ONE = ADW'(1);

  logic [SW-1:0] s_q;
  logic [KW-1:0] k_q;
  logic [SW-1:0] lg;
  logic [SW-1:0] lg2;
  logic [ADW-1:0] len;
  logic [ADW-1:0] grp;
  logic [ADW-1:0] off;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_q <= '0;
      k_q <= '0;
    end else if (clear_i) begin
      s_q <= '0;
      k_q <= '0;
    end else if (advance_i) begin
      k_q <= k_q + KW'(1);
      if (&k_q) begin
        s_q <= (s_q == SW'(ADW - 1)) ? '0 : s_q + SW'(1);
      end
    end
  end

  // lg = log2(len); the group stride 2*len is 1 << (lg + 1).
  always_comb begin
    lg         = SW'(ADW - 1) - s_q;
    lg2        = SW'(ADW) - s_q;
    len        = ONE << lg;
    grp        = {1'b0, k_q} >> lg;
    off        = {1'b0, k_q} & (len - ONE);
    addr_a_o   = (grp << lg2) + off;
    addr_b_o   = addr_a_o + len;
    zeta_idx_o = (ONE << s_q) + grp;
    last_o     = (s_q == SW'(ADW - 1)) && (&k_q);
  end

endmodule

// File: rtl/ntt_bram_sched.sv
// Drives both ports of the coefficient BRAM through one full in-place NTT pass,
// exchanging each coefficient pair with an external butterfly unit.
module ntt_bram_sched
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADW        = ADW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output sched_state_e      state_o,
  ntt_bram_sched_if.master  bus
);

  sched_state_e   state_q;
  logic           last_q;
  logic           gen_clear;
  logic           gen_advance;
  logic [ADW-1:0] gen_addr_a;
  logic [ADW-1:0] gen_addr_b;
  logic [ADW-1:0] gen_zeta;
  logic           gen_last;

  // Counters step when results are taken, so during WRITE the generator
  // already presents the next pair for the following READ.
  assign gen_clear   = (state_q == S_IDLE) && start_i;
  assign gen_advance = (state_q == S_COLLECT) && bus.res_valid_i;
  assign state_o     = state_q;

  ntt_addr_gen #(.ADW(ADW)) u_addr_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (gen_clear),
    .advance_i  (gen_advance),
    .addr_a_o   (gen_addr_a),
    .addr_b_o   (gen_addr_b),
    .zeta_idx_o (gen_zeta),
    .last_o     (gen_last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= S_IDLE;
      last_q            <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      bus.we_a_o        <= 1'b0;
      bus.we_b_o        <= 1'b0;
      bus.addr_a_o      <= '0;
      bus.addr_b_o      <= '0;
      bus.din_a_o       <= '0;
      bus.din_b_o       <= '0;
      bus.bf_valid_o    <= 1'b0;
      bus.bf_u_o        <= '0;
      bus.bf_v_o        <= '0;
      bus.bf_zeta_idx_o <= '0;
    end else begin
      done_o     <= 1'b0;
      bus.we_a_o <= 1'b0;
      bus.we_b_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_o            <= 1'b1;
            bus.addr_a_o      <= gen_addr_a;
            bus.addr_b_o      <= gen_addr_b;
            bus.bf_zeta_idx_o <= gen_zeta;
            state_q           <= S_READ;
          end
        end
        S_READ: state_q <= S_CAPT;
        S_CAPT: begin
          bus.bf_u_o     <= bus.dout_a_i;
          bus.bf_v_o     <= bus.dout_b_i;
          bus.bf_valid_o <= 1'b1;
          state_q        <= S_ISSUE;
        end
        S_ISSUE: begin
          if (bus.bf_ready_i) begin
            bus.bf_valid_o <= 1'b0;
            state_q        <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (bus.res_valid_i) begin
            bus.din_a_o <= bus.res_u_i;
            bus.din_b_o <= bus.res_v_i;
            bus.we_a_o  <= 1'b1;
            bus.we_b_o  <= 1'b1;
            last_q      <= gen_last;
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (last_q) begin
            done_o  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            bus.addr_a_o      <= gen_addr_a;
            bus.addr_b_o      <= gen_addr_b;
            bus.bf_zeta_idx_o <= gen_zeta;
            state_q           <= S_READ;
          end
        end
        S_DONE: begin
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_bram_sched.sv
// Bench for ntt_bram_sched: BRAM and butterfly models, pass-level reference
// built from the stage/group/offset loop nest, directed steps in one block.
module tb_ntt_bram_sched;
  import ntt_pkg::*;

  localparam int DW = 12;
  localparam int AW = 5;
  localparam int N  = 32;
  localparam int NB = 80;

  logic         clk;
  logic         rst;
  logic         start;
  logic         busy;
  logic         done;
  sched_state_e state;

  ntt_bram_sched_if #(.DATA_WIDTH(DW), .ADW(AW)) bus ();

  ntt_bram_sched #(.DATA_WIDTH(DW), .ADW(AW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .busy_o  (busy),
    .done_o  (done),
    .state_o (state),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [DW-1:0] mem     [N];
  logic [DW-1:0] ref_mem [N];
  logic [AW-1:0] exp_a[$], exp_b[$], exp_z[$];
  logic [AW-1:0] wq_a[$], wq_b[$], zq[$];

  logic [DW-1:0] inc = '0;
  bit            rand_ready = 0;
  bit            rand_res = 0;
  bit            inject_issue = 0;
  int            stall_left = 0;
  int            bad_we = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM model: read-first, one-cycle registered read data
  always @(posedge clk) begin
    bus.dout_a_i <= mem[bus.addr_a_o];
    bus.dout_b_i <= mem[bus.addr_b_o];
    if (bus.we_a_o) mem[bus.addr_a_o] = bus.din_a_o;
    if (bus.we_b_o) mem[bus.addr_b_o] = bus.din_b_o;
  end

  // write monitor
  always @(negedge clk) begin
    if (bus.we_a_o || bus.we_b_o) begin
      wq_a.push_back(bus.addr_a_o);
      wq_b.push_back(bus.addr_b_o);
      if (bus.we_a_o !== bus.we_b_o) bad_we++;
    end
  end

  // butterfly responder: res = operand + inc
  initial begin : responder
    bit            pending;
    int            wait_left;
    logic [DW-1:0] pu, pv;
    pending = 0;
    wait_left = 0;
    pu = '0;
    pv = '0;
    bus.bf_ready_i  = 1'b0;
    bus.res_valid_i = 1'b0;
    bus.res_u_i     = '0;
    bus.res_v_i     = '0;
    forever begin
      @(negedge clk);
      bus.res_valid_i = 1'b0;
      if (pending) begin
        if (wait_left == 0) begin
          bus.res_valid_i = 1'b1;
          bus.res_u_i = pu + inc;
          bus.res_v_i = pv + inc;
          pending = 0;
        end else begin
          wait_left--;
        end
      end else begin
        if (bus.bf_valid_o && stall_left > 0) begin
          bus.bf_ready_i = 1'b0;
          stall_left--;
        end else begin
          bus.bf_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (bus.bf_valid_o && bus.bf_ready_i) begin
          pending = 1;
          pu = bus.bf_u_o;
          pv = bus.bf_v_o;
          wait_left = rand_res ? int'($urandom_range(0, 2)) : 0;
          zq.push_back(bus.bf_zeta_idx_o);
          if (inject_issue) begin
            bus.res_valid_i = 1'b1;
            bus.res_u_i = 12'hABC;
            bus.res_v_i = 12'h5A5;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic build_exp();
    int len;
    exp_a.delete(); exp_b.delete(); exp_z.delete();
    for (int s = 0; s < AW; s++) begin
      len = N >> (s + 1);
      for (int g = 0; g < N / (2 * len); g++)
        for (int j = 0; j < len; j++) begin
          exp_a.push_back(AW'(g * 2 * len + j));
          exp_b.push_back(AW'(g * 2 * len + j + len));
          exp_z.push_back(AW'((1 << s) + g));
        end
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < N; i++) begin
      mem[i] = DW'($urandom_range(0, 4095));
      ref_mem[i] = mem[i];
    end
  endtask

  task automatic run_pass(input int glitch_at, input bit stall_chk, output int cycles);
    int n;
    logic [DW-1:0] su, sv;
    logic [AW-1:0] sz;
    wq_a.delete(); wq_b.delete(); zq.delete();
    bad_we = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1;
    check("first_state", state, S_READ);
    check("first_busy", busy, 1);
    check("first_addr_a", bus.addr_a_o, 0);
    check("first_addr_b", bus.addr_b_o, 16);
    check("first_zeta", bus.bf_zeta_idx_o, 1);
    check("first_we", bus.we_a_o, 0);
    if (stall_chk) begin
      while (bus.bf_valid_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      check("stall_reach", bus.bf_valid_o, 1);
      su = bus.bf_u_o; sv = bus.bf_v_o; sz = bus.bf_zeta_idx_o;
      for (int j = 0; j < 7; j++) begin
        check($sformatf("stall_valid%0d", j), bus.bf_valid_o, 1);
        check($sformatf("stall_u%0d", j), bus.bf_u_o, su);
        check($sformatf("stall_v%0d", j), bus.bf_v_o, sv);
        check($sformatf("stall_z%0d", j), bus.bf_zeta_idx_o, sz);
        check($sformatf("stall_we%0d", j), {bus.we_a_o, bus.we_b_o}, 0);
        @(negedge clk); n++;
      end
    end
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk); n++;
      start = (n == glitch_at);
    end
    start = 1'b0;
    cycles = n;
    check("done_seen", done, 1);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
    check("idle_after", state, S_IDLE);
  endtask

  task automatic verify(input string tag);
    check({tag, "_nwr"}, wq_a.size(), NB);
    check({tag, "_nzeta"}, zq.size(), NB);
    check({tag, "_we_pair"}, bad_we, 0);
    for (int i = 0; i < NB && i < wq_a.size(); i++) begin
      check($sformatf("%s_a%0d", tag, i), wq_a[i], exp_a[i]);
      check($sformatf("%s_b%0d", tag, i), wq_b[i], exp_b[i]);
    end
    for (int i = 0; i < NB && i < zq.size(); i++)
      check($sformatf("%s_z%0d", tag, i), zq[i], exp_z[i]);
    if (wq_a.size() == NB && zq.size() == NB) begin
      check({tag, "_s1k8"}, {wq_a[24], wq_b[24], zq[24]}, {5'd16, 5'd24, 5'd3});
      check({tag, "_last"}, {wq_a[79], wq_b[79], zq[79]}, {5'd30, 5'd31, 5'd31});
    end
    for (int i = 0; i < NB; i++) begin
      ref_mem[exp_a[i]] = ref_mem[exp_a[i]] + inc;
      ref_mem[exp_b[i]] = ref_mem[exp_b[i]] + inc;
    end
    for (int i = 0; i < N; i++)
      check($sformatf("%s_mem%0d", tag, i), mem[i], ref_mem[i]);
  endtask

  initial begin : main
    int cyc;
    int n;
    rst = 1'b1;
    start = 1'b0;
    build_exp();
    fill_mem();
    repeat (3) @(negedge clk);
    check("rst_state", state, S_IDLE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", {bus.we_a_o, bus.we_b_o}, 0);
    check("rst_addr", {bus.addr_a_o, bus.addr_b_o}, 0);
    check("rst_din", {bus.din_a_o, bus.din_b_o}, 0);
    check("rst_bf", {bus.bf_valid_o, bus.bf_u_o, bus.bf_v_o, bus.bf_zeta_idx_o}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // identity butterfly, zero-latency handshake
    inc = '0;
    fill_mem();
    run_pass(0, 0, cyc);
    check("id_cycles", cyc, 401);
    verify("id");

    // increment butterfly: every word gains ADW
    inc = 12'd1;
    fill_mem();
    run_pass(0, 0, cyc);
    check("inc_cycles", cyc, 401);
    verify("inc");

    // 7-cycle ready stall on the first issue
    inc = 12'd3;
    fill_mem();
    stall_left = 7;
    run_pass(0, 1, cyc);
    check("stall_cycles", cyc, 408);
    verify("stall");

    // asynchronous reset while writing
    fill_mem();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (bus.we_a_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("arst_reach_write", bus.we_a_o, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_we", {bus.we_a_o, bus.we_b_o}, 0);
    check("arst_busy", busy, 0);
    check("arst_state", state, S_IDLE);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    inc = 12'd1;
    fill_mem();
    run_pass(0, 0, cyc);
    check("arst_cycles", cyc, 401);
    verify("arst");

    // start while busy and res_valid during ISSUE are both ignored
    inc = 12'd7;
    inject_issue = 1;
    fill_mem();
    run_pass(100, 0, cyc);
    inject_issue = 0;
    check("glitch_cycles", cyc, 401);
    verify("glitch");

    // random ready and result latency
    rand_ready = 1;
    rand_res = 1;
    inc = 12'd1;
    fill_mem();
    run_pass(0, 0, cyc);
    rand_ready = 0;
    rand_res = 0;
    check("rand_min_cycles", cyc >= 401, 1);
    verify("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
